// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced push-button sequencer (STOP/RUN/CLEAR) for the 0-9999 counter.
// Define STOPWATCH_LAP_EN to build the lap-hold display path; otherwise lap_active is tied to 0.

module stopwatch_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_lvl;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_lvl  <= sync_meta;
    end
  end

  // Any cycle where the synchronized level agrees with stable restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync_lvl == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_lvl;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_q <= stable;
      press    <= stable & ~stable_q;
    end
  end

endmodule

module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_clear,
  input  logic        btn_mode,
  input  logic        btn_lap,
  input  logic [13:0] count,
  output logic        run,
  output logic        clear,
  output logic        mode,
  output logic [13:0] disp_data,
  output logic        lap_active
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic press_run;
  logic press_clear;
  logic press_mode;

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_run),
    .press (press_run)
  );

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_clear),
    .press (press_clear)
  );

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_mode),
    .press (press_mode)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Clear takes priority over run when both land in the same STOP cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (press_clear) begin
          state_d = ST_CLEAR;
        end else if (press_run) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (press_run) begin
          state_d = ST_STOP;
        end
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  assign run   = (state_q == ST_RUN);
  assign clear = (state_q == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode <= 1'b0;
    end else if (press_mode && (state_q == ST_STOP)) begin
      mode <= ~mode;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        press_lap;
  logic        lap_active_q;
  logic [13:0] lap_reg;

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lap (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lap),
    .press (press_lap)
  );

  // CLEAR is only ever entered from STOP, so state_d alone marks the entry cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_active_q <= 1'b0;
      lap_reg      <= '0;
    end else if (state_d == ST_CLEAR) begin
      lap_active_q <= 1'b0;
    end else if (press_lap) begin
      if ((state_q == ST_RUN) && !lap_active_q) begin
        lap_reg      <= count;
        lap_active_q <= 1'b1;
      end else if ((state_q != ST_CLEAR) && lap_active_q) begin
        lap_active_q <= 1'b0;
      end
    end
  end

  assign lap_active = lap_active_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_data <= '0;
    end else begin
      disp_data <= lap_active_q ? lap_reg : count;
    end
  end
`else
  logic unused_btn_lap;
  assign unused_btn_lap = btn_lap;

  assign lap_active = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_data <= '0;
    end else begin
      disp_data <= count;
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4: vector table plus directed corner sequences.
// Lap sequences follow STOPWATCH_LAP_EN; without it lap_active must stay 0 and disp_data track count.

module tb_stopwatch_ctrl;

  localparam int DEB = 4;
  localparam int B_RUN = 0;
  localparam int B_CLEAR = 1;
  localparam int B_MODE = 2;
  localparam int B_LAP = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_run;
  logic        btn_clear;
  logic        btn_mode;
  logic        btn_lap;
  logic [13:0] count;
  logic        run;
  logic        clear;
  logic        mode;
  logic [13:0] disp_data;
  logic        lap_active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        b_run;
    logic        b_clear;
    logic        b_mode;
    logic        b_lap;
    logic [13:0] cnt;
    int          cycles;
    logic        e_run;
    logic        e_clear;
    logic        e_mode;
    logic [13:0] e_disp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_run    (btn_run),
    .btn_clear  (btn_clear),
    .btn_mode   (btn_mode),
    .btn_lap    (btn_lap),
    .count      (count),
    .run        (run),
    .clear      (clear),
    .mode       (mode),
    .disp_data  (disp_data),
    .lap_active (lap_active)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic e_run, input logic e_clear, input logic e_mode,
                          input logic e_lap, input logic [13:0] e_disp);
    checkOutput({tag, ".run"}, 32'(run), 32'(e_run));
    checkOutput({tag, ".clear"}, 32'(clear), 32'(e_clear));
    checkOutput({tag, ".mode"}, 32'(mode), 32'(e_mode));
    checkOutput({tag, ".lap_active"}, 32'(lap_active), 32'(e_lap));
    checkOutput({tag, ".disp_data"}, 32'(disp_data), 32'(e_disp));
  endtask

  task automatic applyStimulus(input vec_t v);
    btn_run   = v.b_run;
    btn_clear = v.b_clear;
    btn_mode  = v.b_mode;
    btn_lap   = v.b_lap;
    count     = v.cnt;
    tick(v.cycles);
  endtask

  task automatic setBtn(input int which, input logic level);
    case (which)
      B_RUN:   btn_run = level;
      B_CLEAR: btn_clear = level;
      B_MODE:  btn_mode = level;
      default: btn_lap = level;
    endcase
  endtask

  // Long enough for acceptance (8 edges) and for the release to settle.
  task automatic pressBtn(input int which);
    setBtn(which, 1'b1);
    tick(10);
    setBtn(which, 1'b0);
    tick(10);
  endtask

  function automatic vec_t mkVec(input logic r, input logic c, input logic m, input logic [13:0] cnt,
                                 input logic er, input logic em);
    vec_t v;
    v.b_run   = r;
    v.b_clear = c;
    v.b_mode  = m;
    v.b_lap   = 1'b0;
    v.cnt     = cnt;
    v.cycles  = 10;
    v.e_run   = er;
    v.e_clear = 1'b0;
    v.e_mode  = em;
    v.e_disp  = cnt;
    return v;
  endfunction

  initial begin
    int clr_cycles;
    int run_seen;

    vecs.push_back(mkVec(1, 0, 0, 14'd100, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 14'd101, 1, 0));
    vecs.push_back(mkVec(0, 1, 0, 14'd102, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 14'd103, 1, 0));
    vecs.push_back(mkVec(0, 0, 1, 14'd104, 1, 0));
    vecs.push_back(mkVec(0, 0, 0, 14'd105, 1, 0));
    vecs.push_back(mkVec(1, 0, 0, 14'd106, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 14'd107, 0, 0));
    vecs.push_back(mkVec(0, 0, 1, 14'd108, 0, 1));
    vecs.push_back(mkVec(0, 0, 0, 14'd109, 0, 1));
    vecs.push_back(mkVec(1, 0, 0, 14'd110, 1, 1));
    vecs.push_back(mkVec(0, 0, 0, 14'd111, 1, 1));
    vecs.push_back(mkVec(0, 0, 1, 14'd112, 1, 1));
    vecs.push_back(mkVec(0, 0, 0, 14'd113, 1, 1));
    vecs.push_back(mkVec(1, 0, 0, 14'd114, 0, 1));
    vecs.push_back(mkVec(0, 0, 0, 14'd115, 0, 1));
    vecs.push_back(mkVec(0, 0, 1, 14'd116, 0, 0));
    vecs.push_back(mkVec(0, 0, 0, 14'd117, 0, 0));

    reset = 1'b1;
    btn_run = 1'b0;
    btn_clear = 1'b0;
    btn_mode = 1'b0;
    btn_lap = 1'b0;
    count = 14'd0;
    tick(2);
    checkAll("reset", 0, 0, 0, 0, 14'd0);

    // Button steady from edge 0: run must rise at edge 8, not 7.
    reset = 1'b0;
    btn_run = 1'b1;
    tick(7);
    checkOutput("latency_edge7.run", 32'(run), 32'd0);
    tick(1);
    checkOutput("latency_edge8.run", 32'(run), 32'd1);
    btn_run = 1'b0;
    tick(10);
    pressBtn(B_RUN);
    checkOutput("stop_after_latency.run", 32'(run), 32'd0);

    btn_run = 1'b1;
    tick(3);
    btn_run = 1'b0;
    run_seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (run) run_seen++;
    end
    checkOutput("glitch.run_cycles", 32'(run_seen), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("vec%0d", i), vecs[i].e_run, vecs[i].e_clear, vecs[i].e_mode, 1'b0, vecs[i].e_disp);
    end

    pressBtn(B_MODE);
    checkOutput("mode_before_clear", 32'(mode), 32'd1);
    btn_clear = 1'b1;
    tick(7);
    checkOutput("clear_edge7.clear", 32'(clear), 32'd0);
    tick(1);
    checkOutput("clear_edge8.clear", 32'(clear), 32'd1);
    checkOutput("clear_edge8.run", 32'(run), 32'd0);
    tick(1);
    checkOutput("clear_edge9.clear", 32'(clear), 32'd0);
    checkOutput("clear_edge9.run", 32'(run), 32'd0);
    btn_clear = 1'b0;
    tick(10);
    checkOutput("mode_after_clear", 32'(mode), 32'd1);
    pressBtn(B_MODE);
    checkOutput("mode_restore", 32'(mode), 32'd0);

    btn_run = 1'b1;
    btn_clear = 1'b1;
    clr_cycles = 0;
    run_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (clear) clr_cycles++;
      if (run) run_seen++;
    end
    btn_run = 1'b0;
    btn_clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (clear) clr_cycles++;
      if (run) run_seen++;
    end
    checkOutput("simul.clear_cycles", 32'(clr_cycles), 32'd1);
    checkOutput("simul.run_cycles", 32'(run_seen), 32'd0);
    checkOutput("simul.end_run", 32'(run), 32'd0);

`ifdef STOPWATCH_LAP_EN
    count = 14'd50;
    pressBtn(B_LAP);
    checkAll("lap_in_stop", 0, 0, 0, 0, 14'd50);
    pressBtn(B_RUN);
    count = 14'd1234;
    pressBtn(B_LAP);
    checkAll("lap_capture", 1, 0, 0, 1, 14'd1234);
    for (int i = 1; i <= 5; i++) begin
      count = 14'(1234 + i);
      tick(1);
    end
    checkOutput("lap_hold.disp_data", 32'(disp_data), 32'd1234);
    count = 14'd2000;
    pressBtn(B_LAP);
    checkAll("lap_release", 1, 0, 0, 0, 14'd2000);
    count = 14'd2001;
    tick(1);
    checkOutput("lap_follow.disp_data", 32'(disp_data), 32'd2001);
    count = 14'd555;
    pressBtn(B_LAP);
    checkAll("lap_capture2", 1, 0, 0, 1, 14'd555);
    count = 14'd560;
    pressBtn(B_RUN);
    checkAll("lap_stop_keeps", 0, 0, 0, 1, 14'd555);
    count = 14'd600;
    pressBtn(B_CLEAR);
    checkAll("lap_cleared", 0, 0, 0, 0, 14'd600);
`else
    pressBtn(B_RUN);
    count = 14'd1234;
    pressBtn(B_LAP);
    checkAll("nolap_press", 1, 0, 0, 0, 14'd1234);
    count = 14'd1300;
    tick(1);
    checkOutput("nolap_follow.disp_data", 32'(disp_data), 32'd1300);
    pressBtn(B_RUN);
    checkOutput("nolap_stop.run", 32'(run), 32'd0);
`endif

    pressBtn(B_MODE);
    pressBtn(B_RUN);
    count = 14'd4321;
`ifdef STOPWATCH_LAP_EN
    pressBtn(B_LAP);
    checkAll("pre_reset", 1, 0, 1, 1, 14'd4321);
`else
    tick(2);
    checkAll("pre_reset", 1, 0, 1, 0, 14'd4321);
`endif
    // btn_run is already partway through debouncing when reset hits.
    btn_run = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(1);
    checkAll("mid_reset", 0, 0, 0, 0, 14'd0);
    reset = 1'b0;
    tick(7);
    checkOutput("post_reset_edge7.run", 32'(run), 32'd0);
    tick(1);
    checkOutput("post_reset_edge8.run", 32'(run), 32'd1);
    checkOutput("post_reset.disp_data", 32'(disp_data), 32'd4321);
    btn_run = 1'b0;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
